// File: rtl/gng_pkg.sv
// Shared constants and FSM encoding for the multi-cycle GNG datapath stages.
package gng_pkg;

  localparam int GNG_WIDTH      = 16;
  localparam int GNG_SCALE_FRAC = 15;

  // Common state encoding for iterative GNG stages
  typedef enum logic [1:0] {
    GNG_IDLE = 2'd0,
    GNG_MUL  = 2'd1,
    GNG_DONE = 2'd2
  } gng_state_e;

endpackage

// File: rtl/noise_round_sat.sv
// Combinational back end of the scale multiplier: round-half-up, drop the
// fractional bits, clamp to WIDTH bits and suppress negative zero.
module noise_round_sat
  import gng_pkg::*;
#(
  parameter int WIDTH = GNG_WIDTH,
  parameter int FRAC  = GNG_SCALE_FRAC
) (
  input  logic [2*WIDTH:0]  acc,
  input  logic              sign_in,
  output logic [WIDTH-1:0]  product,
  output logic              sat,
  output logic              sign
);

  localparam int AW = 2*WIDTH + 1;
  // Half an LSB of the result, added before truncation
  localparam logic [AW-1:0] HALF = AW'(1) << (FRAC - 1);

  logic [AW-1:0] rounded;
  logic [AW-1:0] shifted;

  // Round, shift, saturate; the accumulator never exceeds (2^W-1)^2 so the
  // extra top bit leaves room for the rounding add without wrapping.
  always_comb begin
    rounded = acc + HALF;
    shifted = rounded >> FRAC;
    if (|shifted[AW-1:WIDTH]) begin
      product = '1;
      sat     = 1'b1;
    end else begin
      product = shifted[WIDTH-1:0];
      sat     = 1'b0;
    end
    sign = sign_in & (|product);
  end

endmodule

// File: rtl/noise_scale_mult.sv
// Sequential shift-add multiplier: product = round_sat((mag*scale) >> FRAC).
// One partial product per cycle, WIDTH cycles per sample, valid/ready both sides.
module noise_scale_mult
  import gng_pkg::*;
#(
  parameter int WIDTH = GNG_WIDTH,
  parameter int FRAC  = GNG_SCALE_FRAC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] mag,
  input  logic             sign_in,
  input  logic [WIDTH-1:0] scale,
  output logic [WIDTH-1:0] product,
  output logic             sign,
  output logic             sat,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int AW = 2*WIDTH + 1;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  gng_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic [WIDTH-1:0] scale_q, scale_d;
  logic             sgn_q, sgn_d;
  logic [WIDTH-1:0] product_q, product_d;
  logic             sign_q, sign_d;
  logic             sat_q, sat_d;
  logic             out_valid_q, out_valid_d;

  logic             accept;
  logic             last_iter;
  logic [AW-1:0]    partial;
  logic [AW-1:0]    acc_step;
  logic [WIDTH-1:0] rs_product;
  logic             rs_sat;
  logic             rs_sign;

  // A new sample can enter when idle or when the held result leaves this edge
  assign in_ready  = (state_q == GNG_IDLE) || ((state_q == GNG_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign last_iter = (cnt_q == CW'(WIDTH - 1));

  // Shifted partial product and this cycle's accumulator update
  always_comb begin
    partial  = {{(WIDTH+1){1'b0}}, mag_q} << cnt_q;
    acc_step = scale_q[cnt_q] ? (acc_q + partial) : acc_q;
  end

  // The final edge's add feeds straight into rounding, so no extra cycle
  noise_round_sat #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_round_sat (
    .acc     (acc_step),
    .sign_in (sgn_q),
    .product (rs_product),
    .sat     (rs_sat),
    .sign    (rs_sign)
  );

  // Next-state, datapath and output-register logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mag_d       = mag_q;
    scale_d     = scale_q;
    sgn_d       = sgn_q;
    product_d   = product_q;
    sign_d      = sign_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;

    case (state_q)
      GNG_IDLE: begin
        if (accept) state_d = GNG_MUL;
      end
      GNG_MUL: begin
        acc_d = acc_step;
        cnt_d = cnt_q + CW'(1);
        if (last_iter) begin
          cnt_d       = '0;
          product_d   = rs_product;
          sign_d      = rs_sign;
          sat_d       = rs_sat;
          out_valid_d = 1'b1;
          state_d     = GNG_DONE;
        end
      end
      GNG_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = accept ? GNG_MUL : GNG_IDLE;
        end
      end
      default: state_d = GNG_IDLE;
    endcase

    // Accept only happens in IDLE or DONE, so this never collides with MUL
    if (accept) begin
      mag_d   = mag;
      scale_d = scale;
      sgn_d   = sign_in;
      acc_d   = '0;
      cnt_d   = '0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= GNG_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      mag_q       <= '0;
      scale_q     <= '0;
      sgn_q       <= 1'b0;
      product_q   <= '0;
      sign_q      <= 1'b0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mag_q       <= mag_d;
      scale_q     <= scale_d;
      sgn_q       <= sgn_d;
      product_q   <= product_d;
      sign_q      <= sign_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign product   = product_q;
  assign sign      = sign_q;
  assign sat       = sat_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_noise_scale_mult.sv
// Bench for noise_scale_mult: directed cases plus randomized samples against
// an arithmetic reference of round-half-up scaled multiplication.
module tb_noise_scale_mult;

  localparam int W = 16;
  localparam int F = 15;
  localparam int LAT = W;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] mag;
  logic         sign_in;
  logic [W-1:0] scale;
  logic [W-1:0] product;
  logic         sign;
  logic         sat;
  logic         out_valid;
  logic         out_ready;

  int n_pass  = 0;
  int n_total = 0;

  noise_scale_mult #(.WIDTH(W), .FRAC(F)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mag       (mag),
    .sign_in   (sign_in),
    .scale     (scale),
    .product   (product),
    .sign      (sign),
    .sat       (sat),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Reference: exact product, round half up, clamp, no negative zero
  task automatic ref_mult(input logic [W-1:0] m, input logic [W-1:0] s, input logic sg,
                          output logic [W-1:0] p, output logic so, output logic st);
    longint unsigned full, r;
    full = longint'(m) * longint'(s);
    r    = (full + (64'd1 << (F - 1))) >> F;
    if (r > 64'd65535) begin p = 16'hFFFF; st = 1'b1; end
    else begin p = r[W-1:0]; st = 1'b0; end
    so = sg && (p != 0);
  endtask

  // Drive one sample from an idle DUT and wait for its result; inputs are
  // scrambled after accept so they must not leak into the product.
  task automatic run_one(input logic [W-1:0] m, input logic [W-1:0] s, input logic sg,
                         output logic [W-1:0] p, output logic so, output logic st,
                         output int lat);
    mag = m; scale = s; sign_in = sg; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    mag = W'($urandom); scale = W'($urandom); sign_in = 1'($urandom);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    p = product; so = sign; st = sat;
    if (out_ready) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; mag = '0; scale = '0; sign_in = 1'b0; out_ready = 1'b1;
    #12;
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
    n_total++; if (product !== 16'h0) $display("FAIL reset_product: got %h want 0000", product); else n_pass++;
    n_total++; if ({sign, sat} !== 2'b00) $display("FAIL reset_sign_sat: got %b want 00", {sign, sat}); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed(input string name, input logic [W-1:0] m,
                               input logic [W-1:0] s, input logic sg);
    logic [W-1:0] p, ep; logic so, st, eso, est; int lat;
    ref_mult(m, s, sg, ep, eso, est);
    run_one(m, s, sg, p, so, st, lat);
    n_total++; if (lat !== LAT) $display("FAIL %s_latency: got %0d want %0d", name, lat, LAT); else n_pass++;
    n_total++; if (p !== ep) $display("FAIL %s_product: got %h want %h", name, p, ep); else n_pass++;
    n_total++; if (so !== eso) $display("FAIL %s_sign: got %b want %b", name, so, eso); else n_pass++;
    n_total++; if (st !== est) $display("FAIL %s_sat: got %b want %b", name, st, est); else n_pass++;
  endtask

  task automatic test_known_values();
    logic [W-1:0] p; logic so, st; int lat;
    run_one(16'hAF0C, 16'h8000, 1'b0, p, so, st, lat);
    n_total++; if ({p, so, st} !== {16'hAF0C, 2'b00}) $display("FAIL unity_fixed: got %h/%b/%b want af0c/0/0", p, so, st); else n_pass++;
    run_one(16'h0003, 16'h4000, 1'b0, p, so, st, lat);
    n_total++; if (p !== 16'h0002) $display("FAIL round_up_fixed: got %h want 0002", p); else n_pass++;
    run_one(16'h0002, 16'h4000, 1'b0, p, so, st, lat);
    n_total++; if (p !== 16'h0001) $display("FAIL round_exact_fixed: got %h want 0001", p); else n_pass++;
    run_one(16'hFFFF, 16'hFFFF, 1'b1, p, so, st, lat);
    n_total++; if ({p, so, st} !== {16'hFFFF, 2'b11}) $display("FAIL sat_fixed: got %h/%b/%b want ffff/1/1", p, so, st); else n_pass++;
    run_one(16'h0000, 16'h8000, 1'b1, p, so, st, lat);
    n_total++; if ({p, so} !== {16'h0000, 1'b0}) $display("FAIL negzero_fixed: got %h/%b want 0000/0", p, so); else n_pass++;
  endtask

  task automatic test_random();
    logic [W-1:0] m, s, p, ep; logic sg, so, st, eso, est; int lat;
    for (int i = 0; i < 24; i++) begin
      m = W'($urandom); s = W'($urandom); sg = 1'($urandom);
      if (i % 6 == 0) s = W'($urandom_range(0, 3));
      if (i % 6 == 1) s = 16'hC000 | W'($urandom);
      ref_mult(m, s, sg, ep, eso, est);
      run_one(m, s, sg, p, so, st, lat);
      n_total++;
      if (lat !== LAT || p !== ep || so !== eso || st !== est)
        $display("FAIL random_%0d: mag=%h scale=%h sgn=%b got %h/%b/%b lat %0d want %h/%b/%b lat %0d",
                 i, m, s, sg, p, so, st, lat, ep, eso, est, LAT);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] p, held, ep; logic so, st, eso, est; int lat; bit stable;
    out_ready = 1'b0;
    ref_mult(16'h5A5A, 16'h6000, 1'b1, ep, eso, est);
    run_one(16'h5A5A, 16'h6000, 1'b1, p, so, st, lat);
    n_total++; if (p !== ep || so !== eso) $display("FAIL bp_first: got %h/%b want %h/%b", p, so, ep, eso); else n_pass++;
    held = product; stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (product !== held || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
      @(posedge clk); #1;
    end
    n_total++; if (stable !== 1'b1) $display("FAIL bp_hold: got %b want 1", stable); else n_pass++;
    in_valid = 1'b1; mag = 16'h1234; scale = 16'h8000; sign_in = 1'b0; out_ready = 1'b1;
    #1;
    n_total++; if (in_ready !== 1'b1) $display("FAIL b2b_in_ready: got %b want 1", in_ready); else n_pass++;
    @(posedge clk); #1;
    in_valid = 1'b0; mag = 16'hFFFF; scale = 16'hFFFF;
    n_total++; if (out_valid !== 1'b0) $display("FAIL b2b_handoff: got %b want 0", out_valid); else n_pass++;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
    n_total++; if (lat !== LAT) $display("FAIL b2b_latency: got %0d want %0d", lat, LAT); else n_pass++;
    n_total++; if (product !== 16'h1234) $display("FAIL b2b_product: got %h want 1234", product); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] p; logic so, st; int lat; bit seen;
    mag = 16'h7777; scale = 16'h8000; sign_in = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    rst = 1'b0;
    #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL midrst_out_valid: got %b want 0", out_valid); else n_pass++;
    n_total++; if (product !== 16'h0) $display("FAIL midrst_product: got %h want 0000", product); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL midrst_in_ready: got %b want 1", in_ready); else n_pass++;
    @(posedge clk); #1; rst = 1'b1;
    seen = 1'b0;
    repeat (30) begin @(posedge clk); #1; if (out_valid === 1'b1) seen = 1'b1; end
    n_total++; if (seen !== 1'b0) $display("FAIL midrst_ghost: got %b want 0", seen); else n_pass++;
    run_one(16'h0101, 16'h8000, 1'b1, p, so, st, lat);
    n_total++;
    if (p !== 16'h0101 || so !== 1'b1 || lat !== LAT)
      $display("FAIL midrst_next: got %h/%b lat %0d want 0101/1 lat %0d", p, so, lat, LAT);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_known_values();
    test_directed("unity", 16'hAF0C, 16'h8000, 1'b0);
    test_directed("round", 16'h0003, 16'h4000, 1'b1);
    test_directed("sat", 16'hFFFF, 16'hFFFF, 1'b1);
    test_directed("zero_mag", 16'h0000, 16'h8000, 1'b1);
    test_directed("zero_scale", 16'hBEEF, 16'h0000, 1'b1);
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
